// File: rtl/fare_event_generator.sv
// fare_event_generator: taximeter FSM turning wheel pulses and second ticks into fare increment pulses.
// Optional night rate (halved distance threshold) via `define FARE_NIGHT_RATE_EN.
module fare_event_generator #(
    parameter logic [15:0] BASE_PULSES = 16'd100,
    parameter logic [15:0] DIST_PULSES = 16'd50,
    parameter logic [15:0] STALL_SECS  = 16'd5,
    parameter logic [15:0] WAIT_SECS   = 16'd60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       wheel_pulse,
    input  logic       sec_tick,
`ifdef FARE_NIGHT_RATE_EN
    input  logic       night,
`endif
    output logic       add_distance,
    output logic       add_time,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE, BASE, RUN, WAIT} state_t;
    state_t cur, nxt, ret, ret_n, cs;
    logic s1, s2, s3, edge_ev;
    logic [15:0] pc, pc_n, stall, stall_n, wc, wc_n, thr;
    logic dist_n, time_n;
    assign edge_ev = s2 & ~s3;
    assign state = cur;
`ifdef FARE_NIGHT_RATE_EN
    assign thr = night ? (DIST_PULSES >> 1) : DIST_PULSES;
`else
    assign thr = DIST_PULSES;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3} <= 3'b000;
            cur <= IDLE;
            ret <= IDLE;
            pc <= '0;
            stall <= '0;
            wc <= '0;
            add_distance <= 1'b0;
            add_time <= 1'b0;
        end else begin
            {s1, s2, s3} <= {wheel_pulse, s1, s2};
            cur <= nxt;
            ret <= ret_n;
            pc <= pc_n;
            stall <= stall_n;
            wc <= wc_n;
            add_distance <= dist_n;
            add_time <= time_n;
        end
    end
    // An edge seen in WAIT is counted as if already back in the stored state.
    always_comb begin
        nxt = cur;
        ret_n = ret;
        pc_n = pc;
        stall_n = stall;
        wc_n = wc;
        dist_n = 1'b0;
        time_n = 1'b0;
        cs = (cur == WAIT) ? ret : cur;
        if (stop) begin
            nxt = IDLE;
        end else if (cur == IDLE) begin
            if (start) begin
                nxt = BASE;
                pc_n = '0;
                stall_n = '0;
                wc_n = '0;
            end
        end else if (edge_ev) begin
            nxt = cs;
            stall_n = '0;
            if (cs == BASE) begin
                pc_n = (pc + 16'd1 == BASE_PULSES) ? 16'd0 : pc + 16'd1;
                nxt = (pc + 16'd1 == BASE_PULSES) ? RUN : BASE;
            end else begin
                dist_n = (pc + 16'd1 == thr);
                pc_n = (pc + 16'd1 == thr) ? 16'd0 : pc + 16'd1;
            end
        end else if (sec_tick) begin
            if (cur == WAIT) begin
                time_n = (wc + 16'd1 == WAIT_SECS);
                wc_n = (wc + 16'd1 == WAIT_SECS) ? 16'd0 : wc + 16'd1;
            end else if (stall + 16'd1 == STALL_SECS) begin
                nxt = WAIT;
                ret_n = cur;
                stall_n = '0;
            end else begin
                stall_n = stall + 16'd1;
            end
        end
    end
endmodule

// File: doc/fare_event_generator.md
FARE_EVENT_GENERATOR -- requirements
Module: fare_event_generator

Interface
REQ-001 SHALL have parameter BASE_PULSES, default 16'd100, wheel pulses covered by the base fare.
REQ-002 SHALL have parameter DIST_PULSES, default 16'd50, wheel pulses per add_distance event; legal range >= 2.
REQ-003 SHALL have parameter STALL_SECS, default 16'd5, seconds without a wheel pulse before waiting time is charged.
REQ-004 SHALL have parameter WAIT_SECS, default 16'd60, waiting seconds per add_time event; legal range >= 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port start, input, 1, one-cycle strobe: passenger boards.
REQ-008 SHALL have port stop, input, 1, one-cycle strobe: passenger alights.
REQ-009 SHALL have port wheel_pulse, input, 1, asynchronous wheel-sensor level.
REQ-010 SHALL have port sec_tick, input, 1, one-cycle strobe once per second, synchronous to clk.
REQ-011 SHALL have port add_distance, output, 1, registered distance-increment pulse to the fare adder.
REQ-012 SHALL have port add_time, output, 1, registered waiting-increment pulse to the fare adder.
REQ-013 SHALL have port state, output, 2, current FSM state: IDLE=0, BASE=1, RUN=2, WAIT=3.

Function
REQ-014 SHALL pass wheel_pulse through a 2-flop synchronizer followed by a rising-edge detector; one edge event per low-to-high transition.
REQ-015 SHALL register add_distance/add_time; each is high exactly one cycle per event and low for at least one cycle between events.
REQ-016 SHALL never assert add_distance and add_time in the same cycle.
REQ-017 SHALL transition IDLE->BASE on start, clearing the pulse, stall and wait counters; start is ignored outside IDLE.
REQ-018 SHALL, in BASE, count edge events; on the event making the count equal BASE_PULSES, go to RUN with the distance counter cleared and no output pulse.
REQ-019 SHALL, in RUN, count edge events; on the event making the count equal DIST_PULSES, pulse add_distance in the next cycle and wrap the counter to 0.
REQ-020 SHALL, in BASE and RUN, count sec_tick since the last edge event; on reaching STALL_SECS, enter WAIT, store the return state (BASE or RUN), and preserve the pulse counters.
REQ-021 SHALL, in WAIT, count sec_tick; on reaching WAIT_SECS, pulse add_time in the next cycle and wrap the counter to 0.
REQ-022 SHALL, in WAIT, on an edge event, return to the stored state, clear the stall counter, keep the wait counter, and count that edge in the returned state.
REQ-023 SHALL go to IDLE from any state on stop; add_distance/add_time are not asserted in the cycle following stop.
REQ-024 SHALL give stop priority over start, edge events and sec_tick when they coincide.
REQ-025 SHALL, when an edge event and sec_tick coincide in BASE/RUN, process the edge and clear the stall counter.
REQ-026 SHALL use 16-bit saturating-free counters; parameters above 16'hFFFF are illegal.
REQ-027 SHALL produce add_distance on the third posedge clk after wheel_pulse is first sampled high (2 sync + 1 output register).

Reset
REQ-028 SHALL, with rst high at posedge clk, set state=IDLE, add_distance=0, add_time=0, synchronizer flops=0, and all counters=0.
REQ-029 SHALL give rst priority over all other inputs, including mid-trip; no output pulse follows a reset.

Configuration
REQ-030 SHALL, with FARE_NIGHT_RATE_EN defined, add input night (1 bit) and use DIST_PULSES/2 (integer) as the RUN threshold while night=1, sampled at each edge event.
REQ-031 SHALL, without FARE_NIGHT_RATE_EN, have no night port and always use DIST_PULSES.

Verification (BASE_PULSES=4, DIST_PULSES=3, STALL_SECS=2, WAIT_SECS=5)
REQ-032 SHALL check: rst, start, 10 wheel edges -> state 1 then 2 after edge 4; add_distance pulses after edges 7 and 10; add_time never.
REQ-033 SHALL check: in RUN, 2 sec_ticks without edges -> state 3; 5 more ticks -> one add_time; 1 edge -> state 2.
REQ-034 SHALL check: stop coincident with edge 7 -> state 0, no add_distance; later edges -> no pulses.
REQ-035 SHALL check: rst asserted at edge 6 mid-RUN -> all outputs 0, state 0; a start is required to resume.
REQ-036 SHALL check: with FARE_NIGHT_RATE_EN and night=1, 6 edges after BASE -> add_distance after edges 1,2,...,6 of RUN (threshold 1).
